// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// ALU_SCHED_LOCK_EN (optional) enables requester lock for carry chains.
package alu_sched_pkg;

    localparam int NUM_REQ_DEF  = 2;
    localparam int DATA_W_DEF   = 16;
    localparam int FUNSEL_W_DEF = 5;
    localparam int FLAGS_W      = 4;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    localparam logic [4:0] FS_ADD16 = 5'b10100;
    localparam logic [4:0] FS_ADC16 = 5'b10101;
    localparam logic [4:0] FS_SUB16 = 5'b10110;
    localparam logic [4:0] FS_ADD8  = 5'b00100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        RESP
    } state_e;

endpackage

// File: rtl/alu_sched_if.sv
// Request/response handshake bundle between requesters and the scheduler.
// ReqLock exists only when ALU_SCHED_LOCK_EN is defined.
interface alu_sched_if #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = 16,
    parameter int FUNSEL_W = 5
);
    logic [NUM_REQ-1:0]          ReqValid;
    logic [NUM_REQ-1:0]          ReqReady;
    logic [NUM_REQ*FUNSEL_W-1:0] ReqFunSel;
    logic [NUM_REQ*DATA_W-1:0]   ReqA;
    logic [NUM_REQ*DATA_W-1:0]   ReqB;
`ifdef ALU_SCHED_LOCK_EN
    logic [NUM_REQ-1:0]          ReqLock;
`endif
    logic [NUM_REQ-1:0]          RspValid;
    logic [NUM_REQ-1:0]          RspReady;
    logic [DATA_W-1:0]           RspData;
    logic [3:0]                  RspFlags;

    modport master (
        output ReqValid, ReqFunSel, ReqA, ReqB, RspReady,
`ifdef ALU_SCHED_LOCK_EN
        output ReqLock,
`endif
        input  ReqReady, RspValid, RspData, RspFlags
    );

    modport slave (
        input  ReqValid, ReqFunSel, ReqA, ReqB, RspReady,
`ifdef ALU_SCHED_LOCK_EN
        input  ReqLock,
`endif
        output ReqReady, RspValid, RspData, RspFlags
    );

endinterface

// File: rtl/alu_sched_rr_arb.sv
// Round-robin grant with registered pointer; optional requester lock
// under ALU_SCHED_LOCK_EN.
module alu_sched_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
`ifdef ALU_SCHED_LOCK_EN
    input  logic [NUM_REQ-1:0] req_lock,
`endif
    input  logic               accept,
    output logic               any,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     win
);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     idx;
    logic [NUM_REQ-1:0] req_m;
`ifdef ALU_SCHED_LOCK_EN
    logic               lock_q, lock_d;
    logic [IDW-1:0]     lock_id_q, lock_id_d;
`endif

    always_comb begin
        req_m = req_valid;
`ifdef ALU_SCHED_LOCK_EN
        // a locked owner is the only requester that may be granted
        if (lock_q) begin
            req_m = '0;
            req_m[lock_id_q] = req_valid[lock_id_q];
        end
`endif
        any = 1'b0;
        win = '0;
        gnt = '0;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NUM_REQ);
            if (!any && req_m[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
        if (any) gnt[win] = 1'b1;

        ptr_d = ptr_q;
        if (accept) ptr_d = IDW'((int'(win) + 1) % NUM_REQ);
`ifdef ALU_SCHED_LOCK_EN
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            lock_d    = req_lock[win];
            lock_id_d = win;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
`ifdef ALU_SCHED_LOCK_EN
            lock_q    <= 1'b0;
            lock_id_q <= '0;
`endif
        end else begin
            ptr_q     <= ptr_d;
`ifdef ALU_SCHED_LOCK_EN
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
`endif
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between requesters: accept, issue, capture, respond.
// ALU_SCHED_LOCK_EN adds ReqLock to keep carry chains atomic.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FUNSEL_W = FUNSEL_W_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    alu_sched_if.slave          bus,
    output logic [DATA_W-1:0]   AluA,
    output logic [DATA_W-1:0]   AluB,
    output logic [FUNSEL_W-1:0] AluFunSel,
    output logic                AluWF,
    input  logic [DATA_W-1:0]   AluOut,
    input  logic [3:0]          AluFlags,
    output logic                Busy
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                state_q, state_d;
    logic [FUNSEL_W-1:0]   fun_q, fun_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [DATA_W-1:0]     res_q, res_d;
    logic [3:0]            flg_q, flg_d;

    logic [NUM_REQ-1:0]    gnt, req_ready, rsp_valid;
    logic [IDW-1:0]        win;
    logic                  any, accept, wf;

    alu_sched_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .clk       (Clock),
        .rst_n     (Reset),
        .req_valid (bus.ReqValid),
`ifdef ALU_SCHED_LOCK_EN
        .req_lock  (bus.ReqLock),
`endif
        .accept    (accept),
        .any       (any),
        .gnt       (gnt),
        .win       (win)
    );

    always_comb begin
        state_d   = state_q;
        fun_d     = fun_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        res_d     = res_q;
        flg_d     = flg_q;
        req_ready = '0;
        rsp_valid = '0;
        wf        = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    accept    = 1'b1;
                    req_ready = gnt;
                    fun_d     = bus.ReqFunSel[int'(win)*FUNSEL_W +: FUNSEL_W];
                    a_d       = bus.ReqA[int'(win)*DATA_W +: DATA_W];
                    b_d       = bus.ReqB[int'(win)*DATA_W +: DATA_W];
                    id_d      = win;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wf    = 1'b1;
                res_d = AluOut;
                // byte ops leave the ALU's upper byte undefined
                if (!fun_q[4]) res_d[DATA_W-1:8] = '0;
                state_d = CAPT;
            end
            CAPT: begin
                flg_d   = AluFlags;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (bus.RspReady[id_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            fun_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            fun_q   <= fun_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    // the grant is combinational, so hold it off while reset is applied
    assign bus.ReqReady = Reset ? req_ready : '0;
    assign bus.RspValid = rsp_valid;
    assign bus.RspData  = res_q;
    assign bus.RspFlags = flg_q;
    assign AluA         = a_q;
    assign AluB         = b_q;
    assign AluFunSel    = fun_q;
    assign AluWF        = wf;
    assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler with a behavioural ALU.
// Lock scenario runs only when ALU_SCHED_LOCK_EN is defined.
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] AluA, AluB, AluOut;
    logic [4:0]  AluFunSel;
    logic        AluWF, Busy;
    logic [3:0]  AluFlags;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  pend_v = 2'b00;
    logic [4:0]  pend_f [2];
    logic [15:0] pend_a [2];
    logic [15:0] pend_b [2];
    logic [1:0]  rsp_rdy = 2'b00;
`ifdef ALU_SCHED_LOCK_EN
    logic [1:0]  pend_l = 2'b00;
`endif
    logic        model_c;

    always #5 Clock = ~Clock;

    alu_sched_if bus ();

    always_comb begin
        bus.ReqValid  = pend_v;
        bus.ReqFunSel = {pend_f[1], pend_f[0]};
        bus.ReqA      = {pend_a[1], pend_a[0]};
        bus.ReqB      = {pend_b[1], pend_b[0]};
        bus.RspReady  = rsp_rdy;
`ifdef ALU_SCHED_LOCK_EN
        bus.ReqLock   = pend_l;
`endif
    end

    alu_op_scheduler dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .bus       (bus),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluFunSel (AluFunSel),
        .AluWF     (AluWF),
        .AluOut    (AluOut),
        .AluFlags  (AluFlags),
        .Busy      (Busy)
    );

    // ALU arithmetic: returns {Z,C,N,O, result}; byte ops keep A's upper byte
    function automatic logic [19:0] alu_calc(input logic [4:0] fs,
                                             input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic cin);
        logic [16:0] s;
        logic [8:0]  s8;
        logic [15:0] r;
        logic z, c, n, o;
        r = a; c = cin; o = 1'b0;
        case (fs)
            FS_ADD16, FS_ADC16: begin
                s = {1'b0, a} + {1'b0, b} + ((fs == FS_ADC16) ? {16'h0, cin} : 17'h0);
                r = s[15:0]; c = s[16];
                o = (a[15] == b[15]) && (r[15] != a[15]);
            end
            FS_SUB16: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[15:0]; c = ~s[16];
                o = (a[15] != b[15]) && (r[15] != a[15]);
            end
            FS_ADD8: begin
                s8 = {1'b0, a[7:0]} + {1'b0, b[7:0]};
                r = {a[15:8], s8[7:0]}; c = s8[8];
                o = (a[7] == b[7]) && (s8[7] != a[7]);
            end
            default: ;
        endcase
        if (fs[4]) begin z = (r == 16'h0); n = r[15]; end
        else begin z = (r[7:0] == 8'h0); n = r[7]; end
        return {z, c, n, o, r};
    endfunction

    // expected response {flags, data}: byte ops report a zero upper byte
    function automatic logic [19:0] ref_rsp(input logic [4:0] fs,
                                            input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic cin);
        logic [19:0] t;
        t = alu_calc(fs, a, b, cin);
        if (!fs[4]) t[15:8] = 8'h00;
        return t;
    endfunction

    logic [19:0] alu_w;
    logic [3:0]  alu_flg_r = 4'h0;
    always_comb alu_w = alu_calc(AluFunSel, AluA, AluB, alu_flg_r[FLAG_C]);
    assign AluOut   = alu_w[15:0];
    assign AluFlags = alu_flg_r;
    always @(posedge Clock) if (AluWF) alu_flg_r <= alu_w[19:16];

    function automatic logic [4:0] rand_fs();
        case ($urandom_range(0, 3))
            0:       return FS_ADD16;
            1:       return FS_ADC16;
            2:       return FS_SUB16;
            default: return FS_ADD8;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic apply_reset();
        pend_v  = 2'b00;
        rsp_rdy = 2'b00;
        Reset   = 1'b0;
        repeat (2) tick();
        Reset   = 1'b1;
        tick();
    endtask

    task automatic post(input int i, input logic [4:0] f,
                        input logic [15:0] a, input logic [15:0] b);
        pend_v[i] = 1'b1;
        pend_f[i] = f;
        pend_a[i] = a;
        pend_b[i] = b;
`ifdef ALU_SCHED_LOCK_EN
        pend_l[i] = 1'b0;
`endif
    endtask

    // waits for a grant, then the response; all waits are bounded
    task automatic serve(input int stall, output int win, output int rid,
                         output logic [15:0] d, output logic [3:0] f,
                         output int lat, output logic [1:0] rr);
        int n;
        n = 0; win = -1; rid = -1; d = '0; f = '0; lat = 0;
        #1;
        while (bus.ReqReady == 2'b00 && n < 20) begin
            tick(); #1; n++;
        end
        rr = bus.ReqReady;
        if (rr == 2'b00) return;
        win = rr[1] ? 1 : 0;
        tick();
        pend_v[win] = 1'b0;
        lat = 1;
        while (bus.RspValid == 2'b00 && lat < 10) begin
            tick(); lat++;
        end
        if (bus.RspValid == 2'b00) return;
        rid = bus.RspValid[1] ? 1 : 0;
        d = bus.RspData;
        f = bus.RspFlags;
        repeat (stall) tick();
        rsp_rdy[rid] = 1'b1;
        tick();
        rsp_rdy = 2'b00;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        post(0, FS_ADD16, 16'h1111, 16'h2222);
        post(1, FS_ADD16, 16'h3333, 16'h4444);
        tick(); #1;
        checks++;
        if ({bus.ReqReady, bus.RspValid, AluWF, Busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b wf=%b busy=%b exp all 0",
                     bus.ReqReady, bus.RspValid, AluWF, Busy);
        end
        checks++;
        if ({bus.RspData, bus.RspFlags} !== 20'h0) begin
            failures++;
            $display("FAIL reset_rsp got data=%h flags=%b exp 0", bus.RspData, bus.RspFlags);
        end
        checks++;
        if ({AluA, AluB, AluFunSel} !== 37'h0) begin
            failures++;
            $display("FAIL reset_alu got a=%h b=%h fs=%b exp 0", AluA, AluB, AluFunSel);
        end
        pend_v = 2'b00;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        post(0, FS_ADD16, 16'h7FFF, 16'h0001);
        #1;
        checks++;
        if (bus.ReqReady !== 2'b01) begin
            failures++;
            $display("FAIL single_ready got=%b exp=01", bus.ReqReady);
        end
        tick();
        pend_v[0] = 1'b0;
        #1;
        checks++;
        if ({AluWF, Busy, AluA, AluB, AluFunSel, bus.ReqReady} !==
            {1'b1, 1'b1, 16'h7FFF, 16'h0001, FS_ADD16, 2'b00}) begin
            failures++;
            $display("FAIL single_issue got wf=%b busy=%b a=%h b=%h fs=%b exp wf=1 busy=1 a=7fff b=0001 fs=10100",
                     AluWF, Busy, AluA, AluB, AluFunSel);
        end
        tick();
        checks++;
        if ({AluWF, bus.RspValid, AluA} !== {1'b0, 2'b00, 16'h7FFF}) begin
            failures++;
            $display("FAIL single_capt got wf=%b vld=%b a=%h exp wf=0 vld=00 a=7fff",
                     AluWF, bus.RspValid, AluA);
        end
        tick();
        checks++;
        if ({bus.RspValid, bus.RspData, bus.RspFlags} !== {2'b01, 16'h8000, 4'b0011}) begin
            failures++;
            $display("FAIL single_rsp got vld=%b data=%h flags=%b exp vld=01 data=8000 flags=0011",
                     bus.RspValid, bus.RspData, bus.RspFlags);
        end
        rsp_rdy = 2'b01;
        tick();
        rsp_rdy = 2'b00;
        checks++;
        if ({bus.RspValid, Busy} !== 3'b000) begin
            failures++;
            $display("FAIL single_done got vld=%b busy=%b exp 00/0", bus.RspValid, Busy);
        end
    endtask

    task automatic test_8bit();
        int win, rid, lat;
        logic [15:0] d;
        logic [3:0] f;
        logic [1:0] rr;
        post(1, FS_ADD8, 16'h12FF, 16'h0001);
        serve(0, win, rid, d, f, lat, rr);
        checks++;
        if ({rr, d, f} !== {2'b10, 16'h0000, 4'b1100} || rid != 1 || lat != 3) begin
            failures++;
            $display("FAIL op8 got rdy=%b rid=%0d data=%h flags=%b lat=%0d exp 10/1/0000/1100/3",
                     rr, rid, d, f, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] expq[$];
        int          expid[$];
        logic [19:0] e;
        int last, prev_cyc, nacc, pend_new, w, eid;
        last = 1; prev_cyc = -1; nacc = 0; pend_new = -1;
        pend_v = 2'b00; rsp_rdy = 2'b00; Reset = 1'b0;
        post(0, rand_fs(), 16'($urandom), 16'($urandom));
        post(1, rand_fs(), 16'($urandom), 16'($urandom));
        tick();
        Reset = 1'b1;
        rsp_rdy = 2'b11;
        model_c = alu_flg_r[FLAG_C];
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (pend_new >= 0) begin
                post(pend_new, rand_fs(), 16'($urandom), 16'($urandom));
                pend_new = -1;
            end
            #1;
            if (bus.RspValid !== 2'b00) begin
                checks++;
                if (expid.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_rsp_unexpected got vld=%b exp 00", bus.RspValid);
                end else begin
                    e = expq.pop_front();
                    eid = expid.pop_front();
                    if (bus.RspValid !== (2'b01 << eid) || {bus.RspFlags, bus.RspData} !== e) begin
                        failures++;
                        $display("FAIL b2b_rsp got vld=%b flags=%b data=%h exp id=%0d flags=%b data=%h",
                                 bus.RspValid, bus.RspFlags, bus.RspData, eid, e[19:16], e[15:0]);
                    end
                end
            end
            if (bus.ReqReady !== 2'b00) begin
                w = bus.ReqReady[1] ? 1 : 0;
                checks++;
                if (!$onehot(bus.ReqReady) || w != (last + 1) % 2) begin
                    failures++;
                    $display("FAIL b2b_grant got rdy=%b exp one-hot id %0d", bus.ReqReady, (last + 1) % 2);
                end
                if (prev_cyc >= 0) begin
                    checks++;
                    if (cyc - prev_cyc != 4) begin
                        failures++;
                        $display("FAIL b2b_spacing got=%0d exp=4", cyc - prev_cyc);
                    end
                end
                e = ref_rsp(pend_f[w], pend_a[w], pend_b[w], model_c);
                model_c = e[16+FLAG_C];
                expq.push_back(e);
                expid.push_back(w);
                last = w; prev_cyc = cyc; nacc++; pend_new = w;
            end
            tick();
        end
        checks++;
        if (nacc < 6) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp>=6", nacc);
        end
        pend_v = 2'b00;
        rsp_rdy = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b, d;
        logic [19:0] e;
        logic [3:0] f;
        logic [1:0] rr;
        int win, rid, lat;
        apply_reset();
        a = 16'($urandom); b = 16'($urandom);
        e = ref_rsp(FS_SUB16, a, b, 1'b0);
        post(1, FS_SUB16, a, b);
        #1;
        checks++;
        if (bus.ReqReady !== 2'b10) begin
            failures++;
            $display("FAIL bp_ready got=%b exp=10", bus.ReqReady);
        end
        tick();
        pend_v[1] = 1'b0;
        post(0, FS_ADD16, 16'h0101, 16'h0202);
        rsp_rdy = 2'b01;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if ({bus.RspValid, bus.RspData, bus.RspFlags, bus.ReqReady, AluWF} !==
                {2'b10, e[15:0], e[19:16], 2'b00, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got vld=%b data=%h flags=%b rdy=%b wf=%b exp 10/%h/%b/00/0",
                         k, bus.RspValid, bus.RspData, bus.RspFlags, bus.ReqReady, AluWF,
                         e[15:0], e[19:16]);
            end
            tick();
        end
        rsp_rdy = 2'b10;
        tick();
        rsp_rdy = 2'b00;
        #1;
        checks++;
        if ({bus.RspValid, Busy, bus.ReqReady} !== {2'b00, 1'b0, 2'b01}) begin
            failures++;
            $display("FAIL bp_release got vld=%b busy=%b rdy=%b exp 00/0/01",
                     bus.RspValid, Busy, bus.ReqReady);
        end
        serve(0, win, rid, d, f, lat, rr);
        checks++;
        if (rid != 0 || d !== 16'h0303) begin
            failures++;
            $display("FAIL bp_next got rid=%0d data=%h exp 0/0303", rid, d);
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] d;
        logic [19:0] e;
        logic [3:0] f;
        logic [1:0] rr;
        int win, rid, lat;
        apply_reset();
        post(0, FS_ADD16, 16'h1234, 16'h1111);
        #1;
        tick();
        pend_v[0] = 1'b0;
        post(1, FS_SUB16, 16'h0050, 16'h0010);
        #1;
        checks++;
        if (AluWF !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_issue got wf=%b exp=1", AluWF);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if ({bus.ReqReady, bus.RspValid, AluWF, Busy, bus.RspData, bus.RspFlags,
             AluA, AluB, AluFunSel} !== 63'h0) begin
            failures++;
            $display("FAIL rst_mid_zero got rdy=%b vld=%b wf=%b busy=%b a=%h b=%h fs=%b exp all 0",
                     bus.ReqReady, bus.RspValid, AluWF, Busy, AluA, AluB, AluFunSel);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.RspValid, bus.ReqReady, Busy} !== 5'b0) begin
                failures++;
                $display("FAIL rst_mid_quiet got vld=%b rdy=%b busy=%b exp 0",
                         bus.RspValid, bus.ReqReady, Busy);
            end
        end
        Reset = 1'b1;
        post(0, FS_ADD8, 16'hAB80, 16'h0080);
        e = ref_rsp(FS_ADD8, 16'hAB80, 16'h0080, 1'b0);
        serve(1, win, rid, d, f, lat, rr);
        checks++;
        if (rr !== 2'b01 || rid != 0 || {f, d} !== e || lat != 3) begin
            failures++;
            $display("FAIL rst_mid_next got rdy=%b rid=%0d flags=%b data=%h lat=%0d exp 01/0/%b/%h/3",
                     rr, rid, f, d, lat, e[19:16], e[15:0]);
        end
        e = ref_rsp(FS_SUB16, 16'h0050, 16'h0010, 1'b0);
        serve(0, win, rid, d, f, lat, rr);
        checks++;
        if (rid != 1 || {f, d} !== e) begin
            failures++;
            $display("FAIL rst_mid_drain got rid=%0d flags=%b data=%h exp 1/%b/%h",
                     rid, f, d, e[19:16], e[15:0]);
        end
    endtask

`ifdef ALU_SCHED_LOCK_EN
    task automatic test_lock();
        logic [15:0] d;
        logic [3:0] f;
        logic [1:0] rr;
        int win, rid, lat;
        apply_reset();
        post(0, FS_ADD16, 16'hFFFF, 16'h0001);
        pend_l[0] = 1'b1;
        post(1, FS_ADD16, 16'h0003, 16'h0004);
        serve(0, win, rid, d, f, lat, rr);
        checks++;
        if (win != 0 || d !== 16'h0000 || f !== 4'b1100) begin
            failures++;
            $display("FAIL lock_first got win=%0d data=%h flags=%b exp 0/0000/1100", win, d, f);
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (bus.ReqReady !== 2'b00) begin
                failures++;
                $display("FAIL lock_holdoff got rdy=%b exp=00", bus.ReqReady);
            end
            tick();
        end
        post(0, FS_ADC16, 16'h0000, 16'h0000);
        serve(0, win, rid, d, f, lat, rr);
        checks++;
        if (win != 0 || d !== 16'h0001 || f !== 4'b0000) begin
            failures++;
            $display("FAIL lock_adc got win=%0d data=%h flags=%b exp 0/0001/0000", win, d, f);
        end
        serve(0, win, rid, d, f, lat, rr);
        checks++;
        if (win != 1 || d !== 16'h0007) begin
            failures++;
            $display("FAIL lock_release got win=%0d data=%h exp 1/0007", win, d);
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0] d;
        logic [19:0] e;
        logic [3:0] f;
        logic [1:0] rr;
        int win, rid, lat, last, ew;
        apply_reset();
        last = 1;
        model_c = alu_flg_r[FLAG_C];
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++)
                if (!pend_v[i] && $urandom_range(0, 9) < 7)
                    post(i, rand_fs(), 16'($urandom), 16'($urandom));
            if (pend_v == 2'b00) post(int'($urandom_range(0, 1)), rand_fs(),
                                      16'($urandom), 16'($urandom));
            ew = pend_v[(last + 1) % 2] ? (last + 1) % 2 : last;
            e = ref_rsp(pend_f[ew], pend_a[ew], pend_b[ew], model_c);
            serve(int'($urandom_range(0, 3)), win, rid, d, f, lat, rr);
            checks++;
            if (!$onehot(rr) || win != ew || rid != ew || {f, d} !== e || lat != 3) begin
                failures++;
                $display("FAIL rand op=%0d got rdy=%b win=%0d rid=%0d flags=%b data=%h lat=%0d exp id=%0d flags=%b data=%h lat=3",
                         n, rr, win, rid, f, d, lat, ew, e[19:16], e[15:0]);
            end
            model_c = e[16+FLAG_C];
            last = ew;
        end
        pend_v = 2'b00;
    endtask

    initial begin
        pend_f[0] = '0; pend_f[1] = '0;
        pend_a[0] = '0; pend_a[1] = '0;
        pend_b[0] = '0; pend_b[1] = '0;
        apply_reset();
        test_reset();
        test_single_op();
        test_8bit();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
`ifdef ALU_SCHED_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
Round-robin scheduler that shares one 16-bit ArithmeticLogicUnit between two requesters (e.g. address-calc path and register-transfer path). It accepts one operation at a time through a valid/ready handshake and drives the ALU's A, B, FunSel and WF. It captures ALUOut and the registered flags, then returns result and flags to the owning requester through a valid/ready response.

Parameters:
NUM_REQ, 2, number of requesters (design and verification cover 2 only)
DATA_W, 16, ALU operand/result width
FUNSEL_W, 5, ALU function-select width

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
ReqValid  input  NUM_REQ  per-requester operation valid
ReqReady  output  NUM_REQ  per-requester accept; one-hot or zero
ReqFunSel  input  NUM_REQ*FUNSEL_W  packed FunSel; requester i at [i*5 +: 5]
ReqA  input  NUM_REQ*DATA_W  packed operand A
ReqB  input  NUM_REQ*DATA_W  packed operand B
RspValid  output  NUM_REQ  per-requester result valid; one-hot or zero
RspReady  input  NUM_REQ  per-requester result accept
RspData  output  DATA_W  result, shared bus
RspFlags  output  4  {Z,C,N,O}, shared bus
AluA  output  DATA_W  to ALU A
AluB  output  DATA_W  to ALU B
AluFunSel  output  FUNSEL_W  to ALU FunSel
AluWF  output  1  to ALU WF
AluOut  input  DATA_W  from ALU ALUOut
AluFlags  input  4  from ALU FlagsOut
Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE. All outputs are 0. Round-robin pointer favours requester 0. Any in-flight operation is dropped and no response is issued.
- FSM states are IDLE, ISSUE, CAPT and RESP.
- IDLE:
  - If any ReqValid is high, pick a winner round-robin, starting at the requester after the last grant.
  - Assert ReqReady[winner] combinationally in that cycle. The transfer occurs on that edge.
  - Latch FunSel, A, B and the winner id. Update the pointer. Go to ISSUE.
- ISSUE (1 cycle):
  - Drive AluA, AluB and AluFunSel from the latched values. AluWF=1.
  - At the closing edge, register AluOut into the result register; the ALU updates its flags.
  - Go to CAPT.
- CAPT (1 cycle):
  - AluWF=0. Operands stay held.
  - At the closing edge, register AluFlags into RspFlags. Go to RESP.
- RESP:
  - RspValid[id]=1. RspData and RspFlags stay stable until RspReady[id] is high at an edge; then go to IDLE.
  - Other RspReady bits are ignored.
- Latency: acceptance edge is cycle 0; RspValid rises after the third edge. Minimum occupancy per operation is 4 cycles.
- While not IDLE, all ReqReady bits are 0, including during backpressure. AluWF is high only in ISSUE.
- 8-bit ops (FunSel[4]=0): RspData[15:8] is forced to 0, because the ALU leaves upper bits undefined/held.
- Outside ISSUE/CAPT, AluA, AluB and AluFunSel hold their last values; AluWF=0.
- A requester that drops ReqValid before acceptance is simply not granted. There is no error.

Optional Feature:
ALU_SCHED_LOCK_EN:
- When defined:
  - Adds input ReqLock[NUM_REQ-1:0], sampled with the request.
  - If an accepted request had ReqLock=1, the arbiter grants only that requester after the response completes. This continues until it submits a request with ReqLock=0, which ends the lock after that op completes.
  - This keeps carry chains (ADD then ADC) atomic.
- When undefined: no ReqLock port; strict round-robin.

Decomposition:
- Package alu_sched_pkg holds:
  - state enum: IDLE, ISSUE, CAPT, RESP
  - DATA_W and FUNSEL_W defaults
  - flag index constants: Z=3, C=2, N=1, O=0
  - FunSel constants: ADD16=5'b10100, ADC16=5'b10101, SUB16=5'b10110, ADD8=5'b00100
- Sub-module alu_sched_rr_arb: combinational round-robin grant from ReqValid and the pointer. It also holds the registered pointer update and the lock mask when the feature is enabled.

Test Plan:
1. Single op: requester 0, FunSel=10100, A=16'h7FFF, B=16'h0001 -> RspValid[0] after 3 edges; RspData=16'h8000, RspFlags=4'b0011.
2. 8-bit op: requester 1, FunSel=00100, A=16'h12FF, B=16'h0001 -> RspData=16'h0000, RspFlags=4'b1100.
3. Both ReqValid held high from reset with RspReady=1 -> grant order 0,1,0,1; exactly one ReqReady per accept.
4. RspReady low for 5 cycles in RESP -> RspValid, RspData and RspFlags stable; ReqReady=0; AluWF=0; the op completes when RspReady rises.
5. Reset asserted during ISSUE -> all outputs 0 immediately; no RspValid; the next request completes normally with requester 0 favoured.
6. (LOCK_EN) req0 ADD16 FFFF+0001 with lock=1 -> 0000, C=1. req1 pending is held off. Then req0 ADC16 0000+0000 with lock=0 -> 16'h0001. req1 is then granted.
